// File: rtl/demux_1to2_stream.sv
// rtl/demux_1to2_stream.sv - 1:2 stream demultiplexer with per-output FIFOs
module demux_1to2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);
  localparam logic [PW:0] OCC_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem [2][DEPTH];
  logic [PW-1:0]    rd_ptr [2];
  logic [PW-1:0]    wr_ptr [2];
  logic [PW:0]      occ [2];
  logic [CNT_W-1:0] cnt [2];
  logic [WIDTH-1:0] head [2];
  logic [WIDTH-1:0] head_next [2];
  logic [1:0]       full;
  logic [1:0]       nonempty;
  logic [1:0]       push;
  logic [1:0]       pop;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]     = (occ[i] == FULL_OCC);
      nonempty[i] = (occ[i] != '0);
    end
    in_ready = in_sel ? !full[1] : !full[0];
    push[0]  = in_valid && in_ready && !in_sel;
    push[1]  = in_valid && in_ready && in_sel;
    pop[0]   = nonempty[0] && out0_ready;
    pop[1]   = nonempty[1] && out1_ready;
    // The head register tracks the oldest word; it keeps the last popped word once empty.
    for (int i = 0; i < 2; i++) begin
      head_next[i] = head[i];
      if (pop[i]) begin
        if (occ[i] > OCC_ONE)
          head_next[i] = mem[i][rd_ptr[i] + PTR_ONE];
        else if (push[i])
          head_next[i] = in_data;
      end else if (!nonempty[i] && push[i]) begin
        head_next[i] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        occ[i]    <= '0;
        cnt[i]    <= '0;
        head[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
          cnt[i]    <= cnt[i] + CNT_W'(1);
        end
        if (pop[i])
          rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        if (push[i] && !pop[i])
          occ[i] <= occ[i] + OCC_ONE;
        else if (pop[i] && !push[i])
          occ[i] <= occ[i] - OCC_ONE;
        head[i] <= head_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i])
        mem[i][wr_ptr[i]] <= in_data;
    end
  end

  assign out0_data  = head[0];
  assign out1_data  = head[1];
  assign out0_valid = nonempty[0];
  assign out1_valid = nonempty[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule
